// File: rtl/design_params_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// design_params_pkg : timer peripheral widths, register map, bus-master types
// Revision 1.0
// ----------------------------------------------------------------------------
package design_params_pkg;

   localparam int P_ADDR_WIDTH = 8;
   localparam int P_DATA_WIDTH = 32;

   localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_CTRL   = 8'h00;
   localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_LOAD   = 8'h04;
   localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_COUNT  = 8'h08;
   localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_STATUS = 8'h0C;

   typedef enum logic [1:0] {
      BM_IDLE = 2'd0,
      BM_REQ  = 2'd1,
      BM_RESP = 2'd2
   } bm_state_e;

   typedef struct packed {
      logic                    write;
      logic [P_ADDR_WIDTH-1:0] addr;
      logic [P_DATA_WIDTH-1:0] wdata;
   } bm_cmd_t;

endpackage
`default_nettype wire

// File: rtl/timer_bus_master_cmd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmd_fifo : synchronous command FIFO with show-ahead head and occupancy count
// Revision 1.0
// ----------------------------------------------------------------------------
module cmd_fifo
   import design_params_pkg::*;
#(
   parameter int P_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  bm_cmd_t                  din,
   output bm_cmd_t                  dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(P_DEPTH):0] count
);

   localparam int                 c_PTR_W = $clog2(P_DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(P_DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);
   localparam logic [c_PTR_W:0]   c_CNT_1 = (c_PTR_W+1)'(1);

   bm_cmd_t            r_mem [P_DEPTH];
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W-1:0] r_rptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_push;
   logic               w_pop;

   assign full   = (r_count == c_FULL);
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign dout   = r_mem[r_rptr];
   // Guard locally so a misbehaving caller can never overrun or underrun.
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_PTR_1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_1;
            2'b01:   r_count <= r_count - c_CNT_1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/timer_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_bus_master : queued core commands executed as req/gnt bus transactions
// Revision 1.0
// ----------------------------------------------------------------------------
module timer_bus_master
   import design_params_pkg::*;
#(
   parameter int P_FIFO_DEPTH = 4,
   parameter int P_TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [P_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [P_DATA_WIDTH-1:0] cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [P_DATA_WIDTH-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_write,
   output logic                    busy,
   output logic                    req,
   input  logic                    gnt,
   output logic [P_ADDR_WIDTH-1:0] addr,
   output logic [P_DATA_WIDTH-1:0] wdata,
   output logic                    write_en,
   input  logic [P_DATA_WIDTH-1:0] rdata
);

   localparam int                 c_CNT_W    = $clog2(P_TIMEOUT) + 1;
   localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(P_TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_1    = c_CNT_W'(1);

   bm_state_e                        r_state,     w_state_nxt;
   logic [c_CNT_W-1:0]               r_tmo_cnt,   w_tmo_cnt_nxt;
   logic                             r_req,       w_req_nxt;
   logic [P_ADDR_WIDTH-1:0]          r_addr,      w_addr_nxt;
   logic [P_DATA_WIDTH-1:0]          r_wdata,     w_wdata_nxt;
   logic                             r_write_en,  w_write_en_nxt;
   logic                             r_rsp_valid, w_rsp_valid_nxt;
   logic [P_DATA_WIDTH-1:0]          r_rsp_rdata, w_rsp_rdata_nxt;
   logic                             r_rsp_err,   w_rsp_err_nxt;
   logic                             r_rsp_write, w_rsp_write_nxt;

   bm_cmd_t                          w_din;
   bm_cmd_t                          w_head;
   logic                             w_full;
   logic                             w_empty;
   logic                             w_push;
   logic                             w_pop;
   logic [$clog2(P_FIFO_DEPTH):0]    w_count;

   assign w_din  = {cmd_write, cmd_addr, cmd_wdata};
   assign w_push = cmd_valid && cmd_ready;

   cmd_fifo #(
      .P_DEPTH (P_FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_push),
      .pop     (w_pop),
      .din     (w_din),
      .dout    (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   assign cmd_ready = !w_full;
   assign busy      = (r_state != BM_IDLE) || (w_count != '0);

   always_comb begin
      w_state_nxt     = r_state;
      w_tmo_cnt_nxt   = r_tmo_cnt;
      w_req_nxt       = r_req;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_write_en_nxt  = r_write_en;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      w_rsp_write_nxt = r_rsp_write;
      w_pop           = 1'b0;
      case (r_state)
         BM_IDLE: begin
            if (!w_empty) begin
               w_pop          = 1'b1;
               w_addr_nxt     = w_head.addr;
               w_wdata_nxt    = w_head.wdata;
               w_write_en_nxt = w_head.write;
               w_req_nxt      = 1'b1;
               w_tmo_cnt_nxt  = '0;
               w_state_nxt    = BM_REQ;
            end
         end
         BM_REQ: begin
            // A grant in the expiry cycle still completes the transaction.
            if (gnt) begin
               w_req_nxt       = 1'b0;
               w_rsp_rdata_nxt = r_write_en ? '0 : rdata;
               w_rsp_err_nxt   = 1'b0;
               w_rsp_write_nxt = r_write_en;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = BM_RESP;
            end else if (r_tmo_cnt == c_TMO_LAST) begin
               w_req_nxt       = 1'b0;
               w_rsp_rdata_nxt = '0;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_write_nxt = r_write_en;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = BM_RESP;
            end else begin
               w_tmo_cnt_nxt   = r_tmo_cnt + c_CNT_1;
            end
         end
         BM_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = BM_IDLE;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = BM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= BM_IDLE;
         r_tmo_cnt   <= '0;
         r_req       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_write_en  <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_write <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tmo_cnt   <= w_tmo_cnt_nxt;
         r_req       <= w_req_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_write_en  <= w_write_en_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_write <= w_rsp_write_nxt;
      end
   end

   assign req       = r_req;
   assign addr      = r_addr;
   assign wdata     = r_wdata;
   assign write_en  = r_write_en;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign rsp_write = r_rsp_write;

endmodule
`default_nettype wire

// File: tb/tb_timer_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_timer_bus_master : scoreboard bench with a register-file peripheral model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_timer_bus_master;
   import design_params_pkg::*;

   localparam int c_DEPTH = 4;
   localparam int c_TMO   = 16;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic                    cmd_valid = 1'b0;
   logic                    cmd_ready;
   logic                    cmd_write = 1'b0;
   logic [P_ADDR_WIDTH-1:0] cmd_addr = '0;
   logic [P_DATA_WIDTH-1:0] cmd_wdata = '0;
   logic                    rsp_valid;
   logic                    rsp_ready = 1'b0;
   logic [P_DATA_WIDTH-1:0] rsp_rdata;
   logic                    rsp_err;
   logic                    rsp_write;
   logic                    busy;
   logic                    req;
   logic                    gnt = 1'b0;
   logic [P_ADDR_WIDTH-1:0] addr;
   logic [P_DATA_WIDTH-1:0] wdata;
   logic                    write_en;
   logic [P_DATA_WIDTH-1:0] rdata = '0;

   always #5 clk = ~clk;

   timer_bus_master #(.P_FIFO_DEPTH(c_DEPTH), .P_TIMEOUT(c_TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_write(rsp_write), .busy(busy),
      .req(req), .gnt(gnt), .addr(addr), .wdata(wdata),
      .write_en(write_en), .rdata(rdata)
   );

   typedef struct {
      logic        write;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   int          delay_q[$];
   logic [31:0] ref_mem [4] = '{default: '0};
   logic [31:0] per_mem [4] = '{default: '0};
   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   int          rdy_mode = 1;   // 0 random, 1 always ready, 2 hold off
   int          cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      chk_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   task automatic fail(input string name);
      chk_cnt++;
      $display("FAIL %s: got no event expected event within bound", name);
   endtask

   // Expected response follows from the command alone: a grant within
   // c_TMO request cycles succeeds, anything slower is a timeout.
   task automatic send(input logic w, input logic [1:0] ri, input logic [31:0] d, input int dly);
      exp_t e;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = {4'h0, ri, 2'b00};
      cmd_wdata = d;
      for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) begin
         fail("cmd_accept");
         cmd_valid = 1'b0;
         return;
      end
      e.write = w;
      e.err   = (dly >= c_TMO);
      e.rdata = (w || e.err) ? 32'h0 : ref_mem[ri];
      if (w && !e.err) ref_mem[ri] = d;
      exp_q.push_back(e);
      delay_q.push_back(dly);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0 && !busy && !rsp_valid) break;
         @(negedge clk);
      end
      if (i == 3000) fail("drain");
   endtask

   // Peripheral: grants after the delay attached to the command, keeps a register file.
   int reqcyc = 0;
   int cur_d  = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         reqcyc = 0;
         gnt    = 1'b0;
      end else if (req) begin
         if (reqcyc == 0) begin
            if (delay_q.size() > 0) cur_d = delay_q.pop_front();
            else begin fail("req_without_cmd"); cur_d = 0; end
         end
         rdata = $urandom;
         if (reqcyc == cur_d) begin
            gnt = 1'b1;
            if (write_en) per_mem[addr[3:2]] = wdata;
            else          rdata = per_mem[addr[3:2]];
         end else begin
            gnt = 1'b0;
         end
         reqcyc++;
      end else begin
         if (reqcyc > 0)
            check("req_high_cycles", 64'(reqcyc), 64'(((cur_d < c_TMO) ? cur_d : c_TMO - 1) + 1));
         reqcyc = 0;
         gnt    = ($urandom_range(0, 7) == 0);
         rdata  = $urandom;
      end
   end

   // Response monitor: pops the scoreboard on each new response, checks hold.
   exp_t        cur;
   bit          checked = 0;
   logic        p_valid = 1'b0;
   logic [33:0] held = '0;
   always begin
      @(posedge clk); #1;
      if (!reset_n) begin
         checked = 0; p_valid = 1'b0; rsp_ready = 1'b0;
      end else begin
         if (p_valid && rsp_ready) checked = 0;
         if (rsp_valid) begin
            if (!checked) begin
               if (exp_q.size() == 0) fail("unexpected_rsp");
               else begin
                  cur = exp_q.pop_front();
                  check("rsp_write", 64'(rsp_write), 64'(cur.write));
                  check("rsp_err",   64'(rsp_err),   64'(cur.err));
                  check("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
               end
               checked = 1;
               held = {rsp_write, rsp_err, rsp_rdata};
            end else begin
               check("rsp_hold", 64'({rsp_write, rsp_err, rsp_rdata}), 64'(held));
            end
         end
         p_valid = rsp_valid;
         case (rdy_mode)
            0:       rsp_ready = 1'($urandom_range(0, 1));
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   // Bus protocol: signals move only when req rises, req drops after gnt, 2-cycle gaps.
   logic                    pc_req = 1'b0;
   logic                    pc_we = 1'b0;
   logic [P_ADDR_WIDTH-1:0] pc_addr = '0;
   logic [P_DATA_WIDTH-1:0] pc_wd = '0;
   int                      low_run = 99;
   always begin
      @(posedge clk); #1;
      if (!reset_n) begin
         pc_req = 1'b0; pc_we = 1'b0; pc_addr = '0; pc_wd = '0; low_run = 99;
      end else begin
         if (!(!pc_req && req))
            check("bus_stable", 64'({addr, wdata, write_en}), 64'({pc_addr, pc_wd, pc_we}));
         if (pc_req && gnt) check("req_drop_after_gnt", 64'(req), 64'(0));
         if (!pc_req && req) check("req_low_gap", 64'(low_run >= 2), 64'(1));
         low_run = req ? 0 : ((low_run < 99) ? low_run + 1 : 99);
         pc_req = req; pc_we = write_en; pc_addr = addr; pc_wd = wdata;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  c0;
      bit  seen;
      repeat (3) @(negedge clk);
      check("rst_req",       64'(req),       64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      check("rst_bus", 64'({addr, wdata, write_en, rsp_rdata, rsp_err, rsp_write}), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // Write then read back the load register.
      send(1'b1, 2'd1, 32'h0000_0010, 2);
      send(1'b0, 2'd1, 32'h0, 1);
      drain();

      // Timeout, then a normal command; then grant racing the expiry.
      send(1'b0, 2'd1, 32'h0, 40);
      send(1'b0, 2'd1, 32'h0, 0);
      drain();
      send(1'b0, 2'd1, 32'h0, c_TMO - 1);
      send(1'b1, 2'd2, 32'hCAFE_F00D, c_TMO - 1);
      send(1'b0, 2'd2, 32'h0, 3);
      drain();

      // Backpressure: 5 accepted back to back, 6th refused, response held.
      rdy_mode = 2;
      c0 = cyc;
      for (int i = 0; i < 5; i++) send(1'b0, 2'(i), 32'h0, 40);
      check("five_accepted_cycles", 64'(cyc - c0), 64'(5));
      check("full_ready_low", 64'(cmd_ready), 64'(0));
      fork
         send(1'b1, 2'd3, 32'h1234_5678, 2);
         begin
            for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
            seen = 1;
            repeat (10) begin @(negedge clk); if (!rsp_valid) seen = 0; end
            check("rsp_valid_held", 64'(seen), 64'(1));
            rdy_mode = 1;
         end
      join
      drain();

      // Reset while a transaction is in flight with three queued.
      for (int i = 0; i < 4; i++) send(1'b0, 2'(i), 32'h0, 30);
      check("pre_reset_req", 64'(req), 64'(1));
      reset_n = 1'b0;
      #1;
      check("mid_rst_req",       64'(req),       64'(0));
      check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("mid_rst_busy",      64'(busy),      64'(0));
      exp_q.delete();
      delay_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (20) begin @(negedge clk); if (req || busy) seen = 1; end
      check("no_txn_after_reset", 64'(seen), 64'(0));
      send(1'b0, 2'd3, 32'h0, 1);
      drain();

      // Randomised traffic.
      rdy_mode = 0;
      for (int n = 0; n < 60; n++) begin
         int dly;
         dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 4));
         send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, dly);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
